// File: rtl/mips32_mem_alu_unit.sv
// MIPS32 datapath support block: instruction memory with program-load port,
// combinational 32-bit ALU, and data memory with synchronous write / combinational read.
module mips32_mem_alu_unit #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_instr,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    input  logic [5:0]  alu_func,
    output logic [31:0] alu_result,
    output logic        alu_zero,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_we,
    input  logic        dmem_re,
    output logic [31:0] dmem_rdata
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam logic [31:0] HLT_WORD = 32'hFC00_0000;

    logic [31:0]    imem_r [IMEM_DEPTH];
    logic [31:0]    dmem_r [DMEM_DEPTH];
    logic [IAW-1:0] imem_ridx_s;
    logic [IAW-1:0] imem_widx_s;
    logic [DAW-1:0] dmem_idx_s;
    logic [31:0]    alu_result_s;
    logic           unused_addr_bits_s;

    // Addresses wrap: only the low index bits select a word.
    assign imem_ridx_s = imem_addr[IAW-1:0];
    assign imem_widx_s = imem_waddr[IAW-1:0];
    assign dmem_idx_s  = dmem_addr[DAW-1:0];
    assign unused_addr_bits_s = ^{imem_addr[31:IAW], imem_waddr[31:IAW], dmem_addr[31:DAW]};

    // Instruction memory: reset fills with HLT, reset has priority over program load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < IMEM_DEPTH; i++) begin
                imem_r[i] <= HLT_WORD;
            end
        end else if (imem_we) begin
            imem_r[imem_widx_s] <= imem_wdata;
        end
    end

    // Instruction fetch is zero-latency.
    assign imem_instr = imem_r[imem_ridx_s];

    // Data memory: reset clears every word and discards a coincident store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_r[i] <= 32'h0000_0000;
            end
        end else if (dmem_we) begin
            dmem_r[dmem_idx_s] <= dmem_wdata;
        end
    end

    // Load data reads pre-edge contents, gated by the load enable.
    always_comb begin
        if (dmem_re) begin
            dmem_rdata = dmem_r[dmem_idx_s];
        end else begin
            dmem_rdata = 32'h0000_0000;
        end
    end

    // ALU operation select; immediates arrive already sign-extended in alu_b.
    always_comb begin
        alu_result_s = 32'h0000_0000;
        case (alu_func)
            6'h20, 6'h21, 6'h08, 6'h23, 6'h2B: alu_result_s = alu_a + alu_b;
            6'h22, 6'h04:                      alu_result_s = alu_a - alu_b;
            6'h24, 6'h0C:                      alu_result_s = alu_a & alu_b;
            6'h25, 6'h0D:                      alu_result_s = alu_a | alu_b;
            6'h26, 6'h0E:                      alu_result_s = alu_a ^ alu_b;
            6'h27:                             alu_result_s = ~(alu_a | alu_b);
            6'h2A: begin
                if ($signed(alu_a) < $signed(alu_b)) begin
                    alu_result_s = 32'h0000_0001;
                end else begin
                    alu_result_s = 32'h0000_0000;
                end
            end
            default:                           alu_result_s = 32'h0000_0000;
        endcase
    end

    assign alu_result = alu_result_s;
    assign alu_zero   = (alu_result_s == 32'h0000_0000);

endmodule

// File: tb/tb_mips32_mem_alu_unit.sv
// Directed-vector self-checking bench for mips32_mem_alu_unit.
module tb_mips32_mem_alu_unit;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_func;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic        dmem_re;
    logic [31:0] dmem_rdata;

    int n_vec;
    int n_miscompare;

    mips32_mem_alu_unit #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_rdata (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscompare++;
            $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic alu_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] f, input logic [31:0] exp_res, input logic exp_zero);
        alu_a    = a;
        alu_b    = b;
        alu_func = f;
        #1;
        check_vec({tag, "_res"}, alu_result, exp_res);
        check_vec({tag, "_zero"}, {31'd0, alu_zero}, {31'd0, exp_zero});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec        = 0;
        n_miscompare = 0;
        reset      = 1'b1;
        imem_addr  = 32'd0;
        imem_we    = 1'b0;
        imem_waddr = 32'd0;
        imem_wdata = 32'd0;
        alu_a      = 32'd0;
        alu_b      = 32'd0;
        alu_func   = 6'd0;
        dmem_addr  = 32'd0;
        dmem_wdata = 32'd0;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Instruction memory after reset and program load
        imem_addr = 32'd5;
        #1 check_vec("imem_reset_hlt", imem_instr, 32'hFC00_0000);
        imem_we    = 1'b1;
        imem_waddr = 32'd5;
        imem_wdata = 32'h2001_000A;
        next_cycle();
        imem_we = 1'b0;
        #1 check_vec("imem_load", imem_instr, 32'h2001_000A);
        imem_addr = 32'h0000_0405;
        #1 check_vec("imem_wrap", imem_instr, 32'h2001_000A);
        imem_addr = 32'd6;
        #1 check_vec("imem_neighbour", imem_instr, 32'hFC00_0000);

        // ALU sweep a=7, b=5
        alu_vec("add",  32'd7, 32'd5, 6'h20, 32'd12, 1'b0);
        alu_vec("sub",  32'd7, 32'd5, 6'h22, 32'd2,  1'b0);
        alu_vec("and",  32'd7, 32'd5, 6'h24, 32'd5,  1'b0);
        alu_vec("or",   32'd7, 32'd5, 6'h25, 32'd7,  1'b0);
        alu_vec("slt",  32'd7, 32'd5, 6'h2A, 32'd0,  1'b1);
        alu_vec("beq",  32'd7, 32'd5, 6'h04, 32'd2,  1'b0);
        alu_vec("hlt",  32'd7, 32'd5, 6'h3F, 32'd0,  1'b1);
        alu_vec("xor",  32'd7, 32'd5, 6'h26, 32'd2,  1'b0);
        alu_vec("nor",  32'd7, 32'd5, 6'h27, 32'hFFFF_FFF8, 1'b0);
        alu_vec("ori",  32'h0000_00F0, 32'hFFFF_FF0F, 6'h0D, 32'hFFFF_FFFF, 1'b0);
        alu_vec("andi", 32'h1234_5678, 32'hFFFF_FF00, 6'h0C, 32'h1234_5600, 1'b0);

        // ALU edge cases
        alu_vec("add_wrap", 32'hFFFF_FFFF, 32'd1, 6'h20, 32'd0, 1'b1);
        alu_vec("slt_neg",  32'hFFFF_FFFE, 32'd1, 6'h2A, 32'd1, 1'b0);
        alu_vec("addi_neg", 32'd10, 32'hFFFF_FFFC, 6'h08, 32'd6, 1'b0);

        // Store then load
        dmem_addr  = 32'd3;
        dmem_wdata = 32'hDEAD_BEEF;
        dmem_we    = 1'b1;
        dmem_re    = 1'b1;
        #1 check_vec("dmem_same_cycle_old", dmem_rdata, 32'd0);
        next_cycle();
        dmem_we = 1'b0;
        #1 check_vec("dmem_after_store", dmem_rdata, 32'hDEAD_BEEF);
        dmem_re = 1'b0;
        #1 check_vec("dmem_re_low", dmem_rdata, 32'd0);

        // Reset clears both memories
        reset = 1'b1;
        next_cycle();
        reset   = 1'b0;
        dmem_re = 1'b1;
        #1 check_vec("dmem_after_reset", dmem_rdata, 32'd0);
        imem_addr = 32'd5;
        #1 check_vec("imem_after_reset", imem_instr, 32'hFC00_0000);

        // Reset wins over a coincident store
        reset      = 1'b1;
        dmem_we    = 1'b1;
        dmem_wdata = 32'h1234_5678;
        next_cycle();
        reset   = 1'b0;
        dmem_we = 1'b0;
        #1 check_vec("dmem_reset_wins", dmem_rdata, 32'd0);

        // Address generation feeding a store and a load
        alu_vec("lw_agen", 32'd100, 32'd4, 6'h23, 32'd104, 1'b0);
        alu_vec("sw_agen", 32'd100, 32'd4, 6'h2B, 32'd104, 1'b0);
        dmem_addr  = alu_result;
        dmem_wdata = 32'd42;
        dmem_we    = 1'b1;
        next_cycle();
        dmem_we = 1'b0;
        #1 check_vec("dmem_load_104", dmem_rdata, 32'd42);
        dmem_addr = 32'd1024 + 32'd104;
        #1 check_vec("dmem_wrap_104", dmem_rdata, 32'd42);
        dmem_addr = 32'd3;
        #1 check_vec("dmem_other_word", dmem_rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
